// File: rtl/player_sprite_sequencer.sv
// Player sprite animation controller: tracks IDLE/WALK/JUMP, facing and walk frame,
// and produces a registered, optionally mirrored, address into the shared player ROM.
module player_sprite_sequencer #(
    parameter int SPRITE_W    = 30,
    parameter int SPRITE_H    = 30,
    parameter int HALF        = 15,
    parameter int WALK_FRAMES = 4,
    parameter int FRAME_HOLD  = 6,
    parameter int ADDR_W      = 13
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic              frame_start,
    input  logic              move_left,
    input  logic              move_right,
    input  logic              jump_req,
    input  logic              on_ground,
    input  logic [9:0]        BallX,
    input  logic [9:0]        BallY,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    output logic [ADDR_W-1:0] rom_address,
    output logic              sprite_hit,
    output logic              facing_left,
    output logic [1:0]        anim_state,
    output logic [2:0]        frame_idx
);

    localparam int HOLD_W = $clog2(FRAME_HOLD + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WALK = 2'd1,
        ST_JUMP = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic              facing_nxt;
    logic [2:0]        walk_idx, walk_idx_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic              dir;

    assign dir        = move_left ^ move_right;
    assign anim_state = state;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            facing_left <= 1'b0;
            walk_idx    <= '0;
            hold_cnt    <= '0;
        end else begin
            state       <= state_nxt;
            facing_left <= facing_nxt;
            walk_idx    <= walk_idx_nxt;
            hold_cnt    <= hold_nxt;
        end
    end

    // Everything holds between frame_start pulses.
    always_comb begin
        state_nxt    = state;
        facing_nxt   = facing_left;
        walk_idx_nxt = walk_idx;
        hold_nxt     = hold_cnt;
        if (frame_start) begin
            if (move_left && !move_right) begin
                facing_nxt = 1'b1;
            end else if (move_right && !move_left) begin
                facing_nxt = 1'b0;
            end

            if (jump_req && on_ground && state != ST_JUMP) begin
                state_nxt = ST_JUMP;
            end else begin
                case (state)
                    ST_JUMP: if (on_ground && !jump_req) state_nxt = dir ? ST_WALK : ST_IDLE;
                    ST_IDLE: if (dir) state_nxt = ST_WALK;
                    ST_WALK: if (!dir) state_nxt = ST_IDLE;
                    default: state_nxt = ST_IDLE;
                endcase
            end

            // Counters only run while staying in WALK; entering or leaving clears them.
            if (state_nxt == ST_WALK && state == ST_WALK) begin
                if (hold_cnt == HOLD_W'(FRAME_HOLD - 1)) begin
                    hold_nxt     = '0;
                    walk_idx_nxt = (walk_idx == 3'(WALK_FRAMES - 1)) ? 3'd0 : walk_idx + 3'd1;
                end else begin
                    hold_nxt = hold_cnt + HOLD_W'(1);
                end
            end else begin
                hold_nxt     = '0;
                walk_idx_nxt = '0;
            end
        end
    end

    always_comb begin
        frame_idx = 3'd0;
        case (state)
            ST_WALK: frame_idx = walk_idx + 3'd1;
            ST_JUMP: frame_idx = 3'(WALK_FRAMES + 1);
            default: frame_idx = 3'd0;
        endcase
    end

    // 12-bit two's complement offsets so sprites near the screen edge never alias into a hit.
    logic [11:0]       lx, ly, ex;
    logic              in_x, in_y, hit_c;
    logic [ADDR_W-1:0] addr_c;

    assign lx    = {2'b00, DrawX} + 12'(HALF) - {2'b00, BallX};
    assign ly    = {2'b00, DrawY} + 12'(HALF) - {2'b00, BallY};
    assign in_x  = !lx[11] && (lx < 12'(SPRITE_W));
    assign in_y  = !ly[11] && (ly < 12'(SPRITE_H));
    assign hit_c = in_x && in_y && blank;
    assign ex    = facing_left ? (12'(SPRITE_W - 1) - lx) : lx;

    assign addr_c = hit_c ? (ADDR_W'(frame_idx) * ADDR_W'(SPRITE_W * SPRITE_H)
                             + ADDR_W'(ly) * ADDR_W'(SPRITE_W) + ADDR_W'(ex))
                          : '0;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_address <= '0;
            sprite_hit  <= 1'b0;
        end else begin
            rom_address <= addr_c;
            sprite_hit  <= hit_c;
        end
    end

endmodule

// File: tb/tb_player_sprite_sequencer.sv
// Bench for player_sprite_sequencer: directed scenarios plus randomized frames/pixels
// compared against a behavioural animation and address model.
module tb_player_sprite_sequencer;

    logic        vga_clk = 1'b0;
    logic        reset_n, frame_start, move_left, move_right, jump_req, on_ground, blank;
    logic [9:0]  BallX, BallY, DrawX, DrawY;
    logic [12:0] rom_address;
    logic        sprite_hit, facing_left;
    logic [1:0]  anim_state;
    logic [2:0]  frame_idx;

    int checks   = 0;
    int failures = 0;

    // Reference model: state 0/1/2, facing, and pulses spent in WALK since entry.
    int m_state  = 0;
    int m_facing = 0;
    int m_pulses = 0;

    player_sprite_sequencer dut (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .frame_start (frame_start),
        .move_left   (move_left),
        .move_right  (move_right),
        .jump_req    (jump_req),
        .on_ground   (on_ground),
        .BallX       (BallX),
        .BallY       (BallY),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .blank       (blank),
        .rom_address (rom_address),
        .sprite_hit  (sprite_hit),
        .facing_left (facing_left),
        .anim_state  (anim_state),
        .frame_idx   (frame_idx)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        checks++;
        assert (obs === 32'(exp)) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int m_frame();
        if (m_state == 0) return 0;
        if (m_state == 1) return 1 + (m_pulses / 6) % 4;
        return 5;
    endfunction

    task automatic model_update();
        int dir;
        int nxt;
        dir = (move_left != move_right) ? 1 : 0;
        if (move_left && !move_right) m_facing = 1;
        else if (move_right && !move_left) m_facing = 0;
        nxt = m_state;
        if (jump_req && on_ground && m_state != 2) nxt = 2;
        else if (m_state == 2) begin
            if (on_ground && !jump_req) nxt = dir;
        end else nxt = dir;
        m_pulses = (nxt == 1 && m_state == 1) ? m_pulses + 1 : 0;
        m_state  = nxt;
    endtask

    task automatic step_frame();
        frame_start = 1'b1;
        @(posedge vga_clk);
        model_update();
        @(negedge vga_clk);
        frame_start = 1'b0;
    endtask

    task automatic check_ctrl(input string tag);
        chk({tag, ".state"}, 32'(anim_state), m_state);
        chk({tag, ".frame"}, 32'(frame_idx), m_frame());
        chk({tag, ".facing"}, 32'(facing_left), m_facing);
    endtask

    task automatic check_pixel(input string tag, input int dx, input int dy, input int bl);
        int lx, ly, ex, hit, addr;
        DrawX = 10'(dx);
        DrawY = 10'(dy);
        blank = (bl != 0);
        lx  = dx + 15 - int'(BallX);
        ly  = dy + 15 - int'(BallY);
        hit = (lx >= 0 && lx < 30 && ly >= 0 && ly < 30 && bl != 0) ? 1 : 0;
        ex  = (m_facing != 0) ? 29 - lx : lx;
        addr = hit ? m_frame() * 900 + ly * 30 + ex : 0;
        @(posedge vga_clk);
        @(negedge vga_clk);
        chk({tag, ".addr"}, 32'(rom_address), addr);
        chk({tag, ".hit"}, 32'(sprite_hit), hit);
    endtask

    task automatic rand_pixel(input string tag);
        int bx, by;
        bx = $urandom_range(20, 600);
        by = $urandom_range(20, 460);
        BallX = 10'(bx);
        BallY = 10'(by);
        check_pixel(tag, bx - 20 + int'($urandom_range(0, 40)),
                    by - 20 + int'($urandom_range(0, 40)),
                    ($urandom_range(0, 3) != 0) ? 1 : 0);
    endtask

    initial begin
        reset_n = 1'b0; frame_start = 1'b0; move_left = 1'b0; move_right = 1'b0;
        jump_req = 1'b0; on_ground = 1'b1; blank = 1'b0;
        BallX = 10'd300; BallY = 10'd200; DrawX = 10'd0; DrawY = 10'd0;
        repeat (3) @(negedge vga_clk);
        chk("rst.addr", 32'(rom_address), 0);
        chk("rst.hit", 32'(sprite_hit), 0);
        chk("rst.facing", 32'(facing_left), 0);
        chk("rst.state", 32'(anim_state), 0);
        chk("rst.frame", 32'(frame_idx), 0);
        reset_n = 1'b1;
        @(negedge vga_clk);

        // Idle frames, then the top-left sprite pixel.
        repeat (3) step_frame();
        check_ctrl("t1");
        check_pixel("t1.px", 285, 185, 1);

        // Walk cycle with move_right held.
        move_right = 1'b1;
        for (int p = 1; p <= 25; p++) begin
            step_frame();
            check_ctrl("t2");
            if (p == 19) chk("t2.frame19", 32'(frame_idx), 4);
        end
        chk("t2.frame25", 32'(frame_idx), 1);

        // Turn left while walking; mirrored top-left pixel.
        move_right = 1'b0; move_left = 1'b1;
        step_frame();
        check_ctrl("t3");
        check_pixel("t3.px", 285, 185, 1);
        chk("t3.addr929", 32'(rom_address), 929);
        repeat (15) rand_pixel("t3.rnd");

        // Jump from WALK, airborne frames, then land with no direction.
        jump_req = 1'b1; on_ground = 1'b1;
        step_frame();
        check_ctrl("t4.jump");
        chk("t4.frame5", 32'(frame_idx), 5);
        jump_req = 1'b0; on_ground = 1'b0;
        for (int i = 0; i < 10; i++) begin
            move_left  = 1'($urandom_range(0, 1));
            move_right = 1'($urandom_range(0, 1));
            step_frame();
            check_ctrl("t4.air");
        end
        repeat (5) rand_pixel("t4.rnd");
        on_ground = 1'b1; move_left = 1'b0; move_right = 1'b0;
        step_frame();
        check_ctrl("t4.land");
        chk("t4.idle", 32'(anim_state), 0);

        // Randomized control and pixel traffic.
        for (int i = 0; i < 80; i++) begin
            move_left  = 1'($urandom_range(0, 1));
            move_right = 1'($urandom_range(0, 1));
            jump_req   = ($urandom_range(0, 7) == 0);
            on_ground  = ($urandom_range(0, 3) != 0);
            step_frame();
            check_ctrl("rnd");
            rand_pixel("rnd.px");
        end

        // Screen-edge and blanking cases.
        BallX = 10'd5; BallY = 10'd100;
        check_pixel("t5.wrap", 630, 100, 1);
        chk("t5.wraphit", 32'(sprite_hit), 0);
        check_pixel("t5.blank", 10, 100, 0);
        chk("t5.blankhit", 32'(sprite_hit), 0);
        check_pixel("t5.edge", 0, 100, 1);
        BallY = 10'd5;
        check_pixel("t5.ywrap", 5, 1020, 1);

        // Asynchronous reset mid-line while walking left.
        move_left = 1'b1; move_right = 1'b0; jump_req = 1'b0; on_ground = 1'b1;
        repeat (2) step_frame();
        check_ctrl("t6.pre");
        BallX = 10'd300; BallY = 10'd200;
        check_pixel("t6.px", 290, 195, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("t6.addr", 32'(rom_address), 0);
        chk("t6.hit", 32'(sprite_hit), 0);
        chk("t6.facing", 32'(facing_left), 0);
        chk("t6.state", 32'(anim_state), 0);
        chk("t6.frame", 32'(frame_idx), 0);
        @(negedge vga_clk);
        frame_start = 1'b1;
        @(negedge vga_clk);
        frame_start = 1'b0;
        blank = 1'b0;
        reset_n = 1'b1;
        m_state = 0; m_facing = 0; m_pulses = 0;
        @(negedge vga_clk);
        check_ctrl("t6.post");
        chk("t6.postaddr", 32'(rom_address), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
